// File: rtl/factorial_job_sequencer.sv
// Job front-end for the factorial engine: operand FIFO, clear/start/wait sequencing, result return.
// Define FACT_OVERFLOW_CHECK_EN to reject operands above 8 without launching them.
module factorial_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_n,
    output logic [15:0] out_result,
    output logic        out_err,
    output logic        busy,
    output logic        eng_rst,
    output logic        eng_start,
    output logic [7:0]  eng_n,
    input  logic        eng_done,
    input  logic [15:0] eng_result
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, reject;
    logic [7:0]    head;
    logic [7:0]    job_n_q, job_n_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_n_q, out_n_d;
    logic [15:0]   out_result_q, out_result_d;
    logic          out_err_q, out_err_d;
    logic          eng_rst_q, eng_rst_d;
    logic          eng_start_q, eng_start_d;
    logic [7:0]    eng_n_q, eng_n_d;

    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_CLEAR);
    assign head     = fifo_q[rd_ptr_q];

`ifdef FACT_OVERFLOW_CHECK_EN
    assign reject = (head > 8'd8);
`else
    assign reject = 1'b0;
`endif

    assign busy       = (state_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_n      = out_n_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign eng_rst    = eng_rst_q;
    assign eng_start  = eng_start_q;
    assign eng_n      = eng_n_q;

    always_comb begin
        state_d      = state_q;
        job_n_d      = job_n_q;
        tmo_d        = tmo_q;
        out_valid_d  = out_valid_q;
        out_n_d      = out_n_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        eng_n_d      = eng_n_q;
        eng_rst_d    = 1'b0;
        eng_start_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // The clear pulse is registered, so the reject decision is made one cycle early.
                if (count_q != '0) begin
                    state_d   = S_CLEAR;
                    eng_rst_d = !reject;
                end
            end
            S_CLEAR: begin
                job_n_d = head;
                if (reject) begin
                    state_d      = S_DRAIN;
                    out_valid_d  = 1'b1;
                    out_n_d      = head;
                    out_result_d = 16'hFFFF;
                    out_err_d    = 1'b1;
                end else begin
                    state_d     = S_LAUNCH;
                    eng_start_d = 1'b1;
                    eng_n_d     = head;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_d      = S_DRAIN;
                    out_valid_d  = 1'b1;
                    out_n_d      = job_n_q;
                    out_result_d = eng_result;
                    out_err_d    = 1'b0;
                end else if (tmo_q == TO_LAST) begin
                    state_d      = S_DRAIN;
                    out_valid_d  = 1'b1;
                    out_n_d      = job_n_q;
                    out_result_d = 16'h0000;
                    out_err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            job_n_q      <= '0;
            tmo_q        <= '0;
            out_valid_q  <= 1'b0;
            out_n_q      <= '0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            eng_rst_q    <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_n_q      <= '0;
        end else begin
            state_q      <= state_d;
            job_n_q      <= job_n_d;
            tmo_q        <= tmo_d;
            out_valid_q  <= out_valid_d;
            out_n_q      <= out_n_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            eng_rst_q    <= eng_rst_d;
            eng_start_q  <= eng_start_d;
            eng_n_q      <= eng_n_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_q[wr_ptr_q] <= in_n;
    end
endmodule
